// File: rtl/uart_cmd_parser.sv
// Frame parser and write sequencer behind uart_rx: [A5][ADDR][LEN][DATA x LEN][CHK].
// The payload is buffered and written out only after its checksum matches.
module uart_cmd_parser #(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_Valid,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    input  logic       i_Wr_Ready,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun,
    output logic       o_Busy
);
    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    localparam logic [1:0] E_CHK = 2'b01;
    localparam logic [1:0] E_TMO = 2'b10;
    localparam logic [1:0] E_LEN = 2'b11;

    localparam int             IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT_CLKS - 2);
    localparam logic [8:0]     LEN_MAX = 9'(MAX_LEN);

    logic [2:0]    state;
    logic [7:0]    addr;
    logic [7:0]    len;
    logic [7:0]    idx;
    logic [7:0]    chk;
    logic [TW-1:0] tmr;
    logic [7:0]    buf_mem [MAX_LEN];

    logic       in_frame;
    logic       timeout;
    logic       hs;
    logic [7:0] nidx;

    // The counter reaches TIMEOUT_CLKS-1 on the edge that ends a silent cycle with
    // tmr == TIMEOUT_CLKS-2, which puts the error pulse TIMEOUT_CLKS cycles after the strobe.
    always_comb begin
        in_frame = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
        timeout  = in_frame && !i_Rx_DV && (tmr == T_LAST);
        hs       = o_Wr_Valid && i_Wr_Ready;
        nidx     = idx + 8'd1;
    end

    assign o_Busy = (state != S_SYNC);

    always_ff @(posedge i_Clock) begin
        if (state == S_DATA && i_Rx_DV)
            buf_mem[idx[IW-1:0]] <= i_Rx_Byte;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= S_SYNC;
            addr         <= 8'd0;
            len          <= 8'd0;
            idx          <= 8'd0;
            chk          <= 8'd0;
            tmr          <= '0;
            o_Wr_Valid   <= 1'b0;
            o_Wr_Addr    <= 8'd0;
            o_Wr_Data    <= 8'd0;
            o_Frame_Done <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Err_Code   <= 2'b00;
            o_Overrun    <= 1'b0;
        end else begin
            o_Frame_Done <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;

            if (in_frame && !i_Rx_DV)
                tmr <= tmr + 1'b1;
            else
                tmr <= '0;

            if (timeout) begin
                state       <= S_SYNC;
                o_Frame_Err <= 1'b1;
                o_Err_Code  <= E_TMO;
            end else begin
                case (state)
                    S_SYNC: begin
                        chk <= 8'd0;
                        idx <= 8'd0;
                        if (i_Rx_DV && i_Rx_Byte == 8'hA5)
                            state <= S_ADDR;
                    end
                    S_ADDR: if (i_Rx_DV) begin
                        addr  <= i_Rx_Byte;
                        chk   <= chk + i_Rx_Byte;
                        state <= S_LEN;
                    end
                    S_LEN: if (i_Rx_DV) begin
                        if (i_Rx_Byte == 8'd0 || {1'b0, i_Rx_Byte} > LEN_MAX) begin
                            state       <= S_SYNC;
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= E_LEN;
                        end else begin
                            len   <= i_Rx_Byte;
                            chk   <= chk + i_Rx_Byte;
                            idx   <= 8'd0;
                            state <= S_DATA;
                        end
                    end
                    S_DATA: if (i_Rx_DV) begin
                        chk <= chk + i_Rx_Byte;
                        if (idx == len - 8'd1) begin
                            idx   <= 8'd0;
                            state <= S_CHK;
                        end else begin
                            idx <= nidx;
                        end
                    end
                    S_CHK: if (i_Rx_DV) begin
                        if (i_Rx_Byte == chk) begin
                            state      <= S_DRAIN;
                            idx        <= 8'd0;
                            o_Wr_Valid <= 1'b1;
                            o_Wr_Addr  <= addr;
                            o_Wr_Data  <= buf_mem[0];
                        end else begin
                            state       <= S_SYNC;
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= E_CHK;
                        end
                    end
                    S_DRAIN: begin
                        if (i_Rx_DV)
                            o_Overrun <= 1'b1;
                        // Address and data only move on a handshake, so a stalled sink sees them stable.
                        if (hs) begin
                            if (idx == len - 8'd1) begin
                                state        <= S_SYNC;
                                o_Wr_Valid   <= 1'b0;
                                o_Wr_Addr    <= 8'd0;
                                o_Wr_Data    <= 8'd0;
                                o_Frame_Done <= 1'b1;
                            end else begin
                                idx       <= nidx;
                                o_Wr_Addr <= o_Wr_Addr + 8'd1;
                                o_Wr_Data <= buf_mem[nidx[IW-1:0]];
                            end
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a frame-level model predicts writes and
// Done/Err events, a negedge monitor checks them, literal timing checks pin the model.
module tb_uart_cmd_parser;
    localparam int ML = 16;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] rxb = 8'd0;
    logic       ready = 1'b1;
    logic       wr_valid, frame_done, frame_err, overrun, busy;
    logic [7:0] wr_addr, wr_data;
    logic [1:0] err_code;

    uart_cmd_parser #(.MAX_LEN(ML), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rxb),
        .o_Wr_Valid(wr_valid), .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data),
        .i_Wr_Ready(ready), .o_Frame_Done(frame_done), .o_Frame_Err(frame_err),
        .o_Err_Code(err_code), .o_Overrun(overrun), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model state: expected writes {addr,data} and frame events (0 = done, else error code).
    logic [15:0] exp_wr[$];
    int          exp_ev[$];
    int          wr_cyc[$];
    int          done_cyc = -1, err_cyc = -1;
    int          done_cnt = 0, err_cnt = 0, ovr_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  pa = 8'd0, pd = 8'd0;
    logic [7:0]  pay [ML];

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_stable", 32'({wr_valid, wr_addr, wr_data}), 32'({1'b1, pa, pd}));
            if (wr_valid && ready) begin
                wr_cyc.push_back(cyc);
                if (exp_wr.size() == 0) check("unexpected_write", 32'({wr_addr, wr_data}), -1);
                else check("write", 32'({wr_addr, wr_data}), 32'(exp_wr.pop_front()));
            end
            if (frame_done) begin
                done_cyc = cyc;
                done_cnt++;
                if (exp_ev.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    check("done_event", exp_ev.pop_front(), 0);
                    check("done_after_all_writes", exp_wr.size(), 0);
                end
            end
            if (frame_err) begin
                err_cyc = cyc;
                err_cnt++;
                if (exp_ev.size() == 0) check("unexpected_err", 32'(err_code), 0);
                else check("err_code", 32'(err_code), exp_ev.pop_front());
            end
            if (overrun) ovr_cnt++;
            prev_stall = wr_valid && !ready;
            pa = wr_addr;
            pd = wr_data;
        end
    end

    task automatic strobe(input logic [7:0] b);
        dv = 1'b1;
        rxb = b;
        @(posedge clk); #1;
        dv = 1'b0;
    endtask

    // Sends A5,a,n,pay[0..n-1],chk; predicts the outcome from the checksum rule.
    task automatic frame(input logic [7:0] a, input int n, input bit force_chk,
                         input logic [7:0] chkv, output int chk_cyc);
        logic [7:0] s;
        logic [7:0] c;
        s = a + 8'(n);
        for (int i = 0; i < n; i++) s = s + pay[i];
        c = force_chk ? chkv : s;
        if (c == s) begin
            for (int i = 0; i < n; i++) exp_wr.push_back({8'(a + 8'(i)), pay[i]});
            exp_ev.push_back(0);
        end else begin
            exp_ev.push_back(1);
        end
        strobe(8'hA5);
        strobe(a);
        strobe(8'(n));
        for (int i = 0; i < n; i++) strobe(pay[i]);
        chk_cyc = cyc;
        strobe(c);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_wr.size() != 0 || exp_ev.size() != 0) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("pending_after_wait", exp_wr.size() + exp_ev.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, s, base, e0, o0, d0;
        logic pat [6];

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(wr_valid), 0);
        check("rst_addr", 32'(wr_addr), 0);
        check("rst_data", 32'(wr_data), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_code", 32'(err_code), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Good frame, ready tied high.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        base = wr_cyc.size();
        frame(8'h10, 3, 1'b1, 8'h79, n);
        wait_drain();
        check("t1_nwr", wr_cyc.size() - base, 3);
        if (wr_cyc.size() >= base + 3) begin
            check("t1_first_wr_cyc", wr_cyc[base] - n, 1);
            check("t1_last_wr_cyc", wr_cyc[base + 2] - n, 3);
        end
        check("t1_done_cyc", done_cyc - n, 4);
        check("t1_no_err", err_cnt, 0);

        // Bad checksum, then a good frame whose sync lands on the error-pulse cycle.
        e0 = err_cnt;
        base = wr_cyc.size();
        frame(8'h10, 3, 1'b1, 8'h78, n);
        s = n;
        frame(8'h10, 3, 1'b0, 8'h00, n);
        wait_drain();
        check("t2_err_cyc", err_cyc - s, 1);
        check("t2_err_cnt", err_cnt - e0, 1);
        check("t2_code", 32'(err_code), 1);
        check("t2_nwr", wr_cyc.size() - base, 3);

        // Address wrap with a stalling sink.
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;
        ready = 1'b0;
        base = wr_cyc.size();
        frame(8'hFE, 3, 1'b1, 8'h07, n);
        for (int i = 0; i < 6; i++) begin
            ready = pat[i];
            @(posedge clk); #1;
        end
        ready = 1'b1;
        wait_drain();
        check("t3_nwr", wr_cyc.size() - base, 3);
        if (wr_cyc.size() >= base + 3) begin
            check("t3_hs0_cyc", wr_cyc[base] - n, 2);
            check("t3_hs2_cyc", wr_cyc[base + 2] - n, 6);
        end
        check("t3_done_cyc", done_cyc - n, 7);

        // Junk before sync, then LEN=0 and LEN=MAX_LEN+1.
        e0 = err_cnt;
        base = wr_cyc.size();
        strobe(8'h00);
        strobe(8'hFF);
        @(posedge clk); #1;
        check("t4_junk_no_err", err_cnt - e0, 0);
        check("t4_junk_idle", 32'(busy), 0);
        exp_ev.push_back(3);
        strobe(8'hA5); strobe(8'h00); strobe(8'h00);
        exp_ev.push_back(3);
        strobe(8'hA5); strobe(8'h00); strobe(8'h11);
        wait_drain();
        check("t4_err_cnt", err_cnt - e0, 2);
        check("t4_code", 32'(err_code), 3);
        check("t4_nwr", wr_cyc.size() - base, 0);

        // Silence after a data byte times out.
        e0 = err_cnt;
        exp_ev.push_back(2);
        strobe(8'hA5); strobe(8'h20); strobe(8'h02);
        s = cyc;
        strobe(8'hAA);
        check("t5_busy", 32'(busy), 1);
        while (cyc < s + TO + 5) begin
            @(posedge clk); #1;
        end
        wait_drain();
        check("t5_err_cyc", err_cyc - s, TO);
        check("t5_code", 32'(err_code), 2);
        check("t5_err_cnt", err_cnt - e0, 1);

        // A byte on the expiry cycle wins and the frame completes.
        e0 = err_cnt;
        base = wr_cyc.size();
        exp_wr.push_back(16'h20AA);
        exp_wr.push_back(16'h21BB);
        exp_ev.push_back(0);
        strobe(8'hA5); strobe(8'h20); strobe(8'h02);
        s = cyc;
        strobe(8'hAA);
        while (cyc < s + TO - 1) begin
            @(posedge clk); #1;
        end
        strobe(8'hBB);
        strobe(8'h87);
        wait_drain();
        check("t5b_no_err", err_cnt - e0, 0);
        check("t5b_nwr", wr_cyc.size() - base, 2);

        // Bytes during a stalled drain are dropped with an overrun pulse each.
        o0 = ovr_cnt;
        pay[0] = 8'h05; pay[1] = 8'h06;
        ready = 1'b0;
        frame(8'h40, 2, 1'b1, 8'h4D, n);
        strobe(8'hA5);
        strobe(8'h33);
        @(posedge clk); #1;
        ready = 1'b1;
        wait_drain();
        check("t6_overrun", ovr_cnt - o0, 2);
        check("t6_idle", 32'(busy), 0);

        // Reset mid-payload aborts silently; the next frame parses.
        e0 = err_cnt;
        d0 = done_cnt;
        strobe(8'hA5); strobe(8'h30); strobe(8'h04); strobe(8'h01); strobe(8'h02);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_valid", 32'(wr_valid), 0);
        check("t7_rst_code", 32'(err_code), 0);
        check("t7_rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        pay[0] = 8'h09; pay[1] = 8'h08;
        frame(8'h50, 2, 1'b0, 8'h00, n);
        wait_drain();
        check("t7_no_err", err_cnt - e0, 0);
        check("t7_one_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame parser and write sequencer behind the `uart_rx` byte receiver. It consumes the received byte stream (`i_Rx_DV`/`i_Rx_Byte`) and delineates frames of the form `[0xA5][ADDR][LEN][DATA×LEN][CHK]`. It buffers the payload, verifies the checksum, and only then issues the payload as a burst of register writes over a valid/ready port. Bad, short or stalled frames are dropped whole and reported; no partial writes ever reach the register bank.

## Interface
- `MAX_LEN`, default 16: payload buffer depth in bytes; legal LEN is 1..MAX_LEN.
- `TIMEOUT_CLKS`, default 43400: max clocks between consecutive bytes inside a frame (10 byte times at 434 clks/bit).
- `i_Clock` in 1: single clock, same domain as `uart_rx`.
- `i_Reset` in 1: reset, asynchronous, active-high.
- `i_Rx_DV` in 1: one-cycle strobe, `i_Rx_Byte` valid.
- `i_Rx_Byte` in 8: received byte.
- `o_Wr_Valid` out 1: write request; held until accepted.
- `o_Wr_Addr` out 8: write address.
- `o_Wr_Data` out 8: write data.
- `i_Wr_Ready` in 1: sink accepts the write when high with `o_Wr_Valid`.
- `o_Frame_Done` out 1: one-cycle pulse, frame fully written.
- `o_Frame_Err` out 1: one-cycle pulse, frame discarded.
- `o_Err_Code` out 2: last error cause (01 checksum, 10 timeout, 11 bad LEN); holds until the next error.
- `o_Overrun` out 1: one-cycle pulse, byte dropped during drain.
- `o_Busy` out 1: high in every state except S_SYNC.

## Operation
- States:
  - S_SYNC: wait for 0xA5. Any other byte is ignored silently.
  - S_ADDR: latch ADDR, go to S_LEN.
  - S_LEN: if LEN==0 or LEN>MAX_LEN, raise error 11 and go to S_SYNC. Otherwise latch LEN and go to S_DATA.
  - S_DATA: store bytes into buf[0..LEN-1]. After LEN bytes, go to S_CHK.
  - S_CHK: if CHK == (ADDR+LEN+ΣDATA) mod 256, go to S_DRAIN. Otherwise raise error 01 and go to S_SYNC.
  - S_DRAIN: issue LEN writes, then go to S_SYNC with `o_Frame_Done`.
- Checksum: 8-bit running sum that wraps mod 256. Cleared in S_SYNC; accumulates ADDR, LEN and every DATA byte.
- Drain: write i carries `o_Wr_Addr` = ADDR+i (8-bit wrap: 0xFE,0xFF,0x00…) and `o_Wr_Data` = buf[i].
  - `o_Wr_Addr` and `o_Wr_Data` must stay stable while `o_Wr_Valid` is high and `i_Wr_Ready` is low.
  - Advance i only on `o_Wr_Valid && i_Wr_Ready`.
- Timeout: a counter runs in S_ADDR..S_CHK and clears on every `i_Rx_DV`.
  - When it reaches TIMEOUT_CLKS-1, raise error 10 and go to S_SYNC.
  - The timeout is inactive in S_SYNC and S_DRAIN.
- Bytes arriving in S_DRAIN are discarded and pulse `o_Overrun`. The drain itself is unaffected.
- Error handling: pulse `o_Frame_Err`, update `o_Err_Code`, and discard buffer contents. No write is issued for that frame.

## Timing
- Reset (async assert): state S_SYNC. All outputs 0, including `o_Err_Code`=00. Counters and checksum 0.
- Reset mid-frame or mid-drain: immediate abort. No further writes and no Done/Err pulse.
- All outputs are registered.
- CHK byte strobe on cycle N → state S_DRAIN and `o_Wr_Valid`=1 on N+1.
- With `i_Wr_Ready` tied high, one write per cycle: writes occupy N+1..N+LEN.
- `o_Frame_Done` is high for exactly one cycle, the cycle after the final handshake. The parser is already in S_SYNC that cycle and accepts 0xA5 on it.
- Error on a byte at cycle N → `o_Frame_Err` pulse at N+1, state S_SYNC at N+1.
- Timeout: `o_Frame_Err` at TIMEOUT_CLKS cycles after the last strobe.
- `i_Rx_DV` in the same cycle as timeout expiry: the byte wins. It is processed normally and the counter restarts.
- 0xA5 appearing inside ADDR/LEN/DATA/CHK is data, not resync.
- Back-to-back frames: the sync byte may arrive on the `o_Frame_Done` cycle or on the cycle after an error pulse.

## Test plan
- Valid frame A5 10 03 11 22 33 79, ready tied 1 → writes (10,11),(11,22),(12,33) on three consecutive cycles starting 1 cycle after the CHK strobe; Done pulse once; Err never.
- Same frame with CHK=0x78 → `o_Frame_Err`=1 for one cycle, `o_Err_Code`=01, zero writes; next good frame writes normally.
- A5 FE 03 01 02 03 07 with `i_Wr_Ready` toggling 0,1,0,0,1,1 → addresses FE,FF,00 in order; addr/data stable while stalled; Done after third handshake.
- A5 00 00 and A5 00 11 (MAX_LEN=16) → error 11 each, no writes; leading junk bytes 00 FF before A5 → ignored, no Err.
- A5 20 02 AA then silence → Err with code 10 exactly TIMEOUT_CLKS cycles after the AA strobe; byte arriving on the expiry cycle instead → no error.
- Byte strobed during drain → `o_Overrun` pulse, drain completes intact; `i_Reset` pulsed mid-S_DATA → all outputs 0 immediately, no Done/Err, next frame parses.
